// File: rtl/fpn_add_sub_correction_pkg.sv
// Shared command encodings and sequencer state type for the F(p^k) add/sub/correction unit.
package fpn_add_sub_correction_pkg;

   typedef enum logic [2:0] {
      CMD_NOP   = 3'd0,
      CMD_ADD   = 3'd1,
      CMD_SUB   = 3'd2,
      CMD_RAW   = 3'd3,
      CMD_SUB2P = 3'd4,
      CMD_SUB4P = 3'd5,
      CMD_NEG   = 3'd6,
      CMD_BAD   = 3'd7
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PH0,
      ST_PH1,
      ST_FIN
   } state_e;

   function automatic logic cmd_legal(input logic [2:0] c);
      return (c != 3'd0) && (c != 3'd7);
   endfunction

endpackage

// File: rtl/fpn_add_sub_correction_if.sv
// Host-side command/status and result readback bundle.
interface fpn_add_sub_correction_if #(
   parameter int LANES      = 2,
   parameter int RADIX      = 32,
   parameter int DIGITS_LOG = 4
);
   logic                    start;
   logic [2:0]              cmd;
   logic [LANES-1:0]        lane_en;
   logic                    mem_c_rd_en;
   logic [DIGITS_LOG-1:0]   mem_c_rd_addr;
   logic [LANES*RADIX-1:0]  mem_c_dout;
   logic [LANES-1:0]        corr_flags;
   logic                    busy;
   logic                    done;
   logic                    cmd_err;

   modport master (
      output start, cmd, lane_en, mem_c_rd_en, mem_c_rd_addr,
      input  mem_c_dout, corr_flags, busy, done, cmd_err
   );

   modport slave (
      input  start, cmd, lane_en, mem_c_rd_en, mem_c_rd_addr,
      output mem_c_dout, corr_flags, busy, done, cmd_err
   );
endinterface

// File: rtl/fpn_add_sub_correction_lane.sv
// One GF(p) coordinate: digit-serial adder with per-phase carry, LSB-first >=2p comparator,
// R0/R1 result buffers and the lane's correction flag.
module fpn_add_sub_correction_lane
   import fpn_add_sub_correction_pkg::*;
#(
   parameter int RADIX      = 32,
   parameter int DIGITS     = 14,
   parameter int DIGITS_LOG = $clog2(DIGITS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  clr_flag,
   input  cmd_e                  cmd,
   input  logic                  proc_vld,
   input  logic                  proc_ph1,
   input  logic [DIGITS_LOG-1:0] proc_addr,
   input  logic                  r0_rd_en,
   input  logic [DIGITS_LOG-1:0] r0_rd_addr,
   input  logic [RADIX-1:0]      a_dig,
   input  logic [RADIX-1:0]      b_dig,
   input  logic [RADIX-1:0]      px2_dig,
   input  logic [RADIX-1:0]      px4_dig,
   input  logic                  c_rd_en,
   input  logic [DIGITS_LOG-1:0] c_rd_addr,
   output logic [RADIX-1:0]      c_dout,
   output logic                  flag
);

   logic [RADIX-1:0] r0_mem [DIGITS];
   logic [RADIX-1:0] r1_mem [DIGITS];
   logic [RADIX-1:0] r0_q, x, y, sum;
   logic             cin, cout, carry_q, ge_q, zero_q, ge_d, zero_d, flag_d;
   logic             first, last, sel_r1;

   assign first  = (proc_addr == '0);
   assign last   = (proc_addr == DIGITS_LOG'(DIGITS - 1));
   assign sel_r1 = (cmd == CMD_SUB2P) || (cmd == CMD_SUB4P) || flag;

   // Negation folds 2p into PH0 so that R1 = R0 - 2p is the a==0 fix-up, like a corrected add.
   always_comb begin
      x   = a_dig;
      y   = b_dig;
      cin = 1'b0;
      if (!proc_ph1) begin
         case (cmd)
            CMD_SUB, CMD_SUB2P, CMD_SUB4P: begin y = ~b_dig; cin = 1'b1; end
            CMD_NEG: begin x = ~a_dig; y = px2_dig; cin = 1'b1; end
            default: ;
         endcase
      end else begin
         x = r0_q;
         case (cmd)
            CMD_ADD, CMD_NEG:   begin y = ~px2_dig; cin = 1'b1; end
            CMD_SUB, CMD_SUB2P: y = px2_dig;
            CMD_SUB4P:          y = px4_dig;
            default:            y = '0;
         endcase
      end
      {cout, sum} = {1'b0, x} + {1'b0, y} + {{RADIX{1'b0}}, (first ? cin : carry_q)};

      if (sum > px2_dig)      ge_d = 1'b1;
      else if (sum < px2_dig) ge_d = 1'b0;
      else                    ge_d = first ? 1'b1 : ge_q;
      zero_d = (first ? 1'b1 : zero_q) & (a_dig == '0);

      case (cmd)
         CMD_ADD: flag_d = ge_d | cout;
         CMD_SUB: flag_d = ~cout;
         CMD_NEG: flag_d = zero_d;
         default: flag_d = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         carry_q <= 1'b0;
         ge_q    <= 1'b0;
         zero_q  <= 1'b0;
         flag    <= 1'b0;
         c_dout  <= '0;
      end else begin
         if (clr_flag) flag <= 1'b0;
         if (proc_vld && en) begin
            carry_q <= cout;
            if (!proc_ph1) begin
               ge_q   <= ge_d;
               zero_q <= zero_d;
               if (last) flag <= flag_d;
            end
         end
         if (c_rd_en)
            c_dout <= !en ? '0 : (sel_r1 ? r1_mem[c_rd_addr] : r0_mem[c_rd_addr]);
      end
   end

   always_ff @(posedge clk) begin
      if (proc_vld && en) begin
         if (!proc_ph1) r0_mem[proc_addr] <= sum;
         else           r1_mem[proc_addr] <= sum;
      end
      if (r0_rd_en) r0_q <= r0_mem[r0_rd_addr];
   end

endmodule

// File: rtl/fpn_add_sub_correction.sv
// Multi-lane digit-serial F(p^k) add/sub/correction unit: sequencer, operand/constant
// addressing and per-lane datapaths.
//
// state   | meaning
// IDLE    | waiting for start; done/cmd_err pulses visible here
// PH0     | stream a,b (and 2p for add/neg) LSB first into R0, one drain cycle
// PH1     | stream R0 and 2p/4p into R1, two drain cycles
// FIN     | last write settled; done issued on return to IDLE
module fpn_add_sub_correction
   import fpn_add_sub_correction_pkg::*;
#(
   parameter int RADIX      = 32,
   parameter int DIGITS     = 14,
   parameter int DIGITS_LOG = $clog2(DIGITS),
   parameter int LANES      = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   fpn_add_sub_correction_if.slave bus,
   output logic                    mem_a_rd_en,
   output logic [DIGITS_LOG-1:0]   mem_a_rd_addr,
   input  logic [LANES*RADIX-1:0]  mem_a_dout,
   output logic                    mem_b_rd_en,
   output logic [DIGITS_LOG-1:0]   mem_b_rd_addr,
   input  logic [LANES*RADIX-1:0]  mem_b_dout,
   output logic                    px2_mem_rd_en,
   output logic [DIGITS_LOG-1:0]   px2_mem_rd_addr,
   input  logic [RADIX-1:0]        px2_mem_dout,
   output logic                    px4_mem_rd_en,
   output logic [DIGITS_LOG-1:0]   px4_mem_rd_addr,
   input  logic [RADIX-1:0]        px4_mem_dout
);

   localparam int CW = $clog2(DIGITS + 2);

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   cmd_e                  cmd_q;
   logic [LANES-1:0]      lane_en_q, flags;
   logic                  accept, issue, op_issue, r0_issue;
   logic [DIGITS_LOG-1:0] issue_addr, proc_addr_q;
   logic                  proc_vld_q, proc_ph1_q, done_q, err_q;
   logic [LANES*RADIX-1:0] c_dout;

   assign accept     = bus.start && cmd_legal(bus.cmd) && (state_q == ST_IDLE);
   assign issue      = ((state_q == ST_PH0) || (state_q == ST_PH1)) && (cnt_q < CW'(DIGITS));
   assign op_issue   = issue && (state_q == ST_PH0);
   assign r0_issue   = issue && (state_q == ST_PH1);
   assign issue_addr = issue ? DIGITS_LOG'(cnt_q) : '0;

   assign mem_a_rd_en     = op_issue;
   assign mem_b_rd_en     = op_issue;
   assign mem_a_rd_addr   = op_issue ? issue_addr : '0;
   assign mem_b_rd_addr   = op_issue ? issue_addr : '0;
   assign px2_mem_rd_en   = (op_issue && ((cmd_q == CMD_ADD) || (cmd_q == CMD_NEG))) ||
                            (r0_issue && (cmd_q != CMD_SUB4P));
   assign px4_mem_rd_en   = r0_issue && (cmd_q == CMD_SUB4P);
   assign px2_mem_rd_addr = px2_mem_rd_en ? issue_addr : '0;
   assign px4_mem_rd_addr = px4_mem_rd_en ? issue_addr : '0;

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.done       = done_q;
   assign bus.cmd_err    = err_q;
   assign bus.corr_flags = flags;
   assign bus.mem_c_dout = c_dout;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: if (accept) begin state_d = ST_PH0; cnt_d = '0; end
         ST_PH0: begin
            if (cnt_q == CW'(DIGITS)) begin
               state_d = (cmd_q == CMD_RAW) ? ST_FIN : ST_PH1;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         ST_PH1: begin
            if (cnt_q == CW'(DIGITS + 1)) begin
               state_d = ST_FIN;
               cnt_d   = '0;
            end else cnt_d = cnt_q + CW'(1);
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cmd_q       <= CMD_NOP;
         lane_en_q   <= '0;
         proc_vld_q  <= 1'b0;
         proc_ph1_q  <= 1'b0;
         proc_addr_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         if (accept) begin
            cmd_q     <= cmd_e'(bus.cmd);
            lane_en_q <= bus.lane_en;
         end
         proc_vld_q  <= issue;
         proc_ph1_q  <= (state_q == ST_PH1);
         proc_addr_q <= issue_addr;
         done_q      <= (state_q == ST_FIN);
         err_q       <= bus.start && !accept;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      fpn_add_sub_correction_lane #(
         .RADIX      (RADIX),
         .DIGITS     (DIGITS),
         .DIGITS_LOG (DIGITS_LOG)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .en         (lane_en_q[i]),
         .clr_flag   (accept),
         .cmd        (cmd_q),
         .proc_vld   (proc_vld_q),
         .proc_ph1   (proc_ph1_q),
         .proc_addr  (proc_addr_q),
         .r0_rd_en   (r0_issue),
         .r0_rd_addr (issue_addr),
         .a_dig      (mem_a_dout[i*RADIX +: RADIX]),
         .b_dig      (mem_b_dout[i*RADIX +: RADIX]),
         .px2_dig    (px2_mem_dout),
         .px4_dig    (px4_mem_dout),
         .c_rd_en    (bus.mem_c_rd_en),
         .c_rd_addr  (bus.mem_c_rd_addr),
         .c_dout     (c_dout[i*RADIX +: RADIX]),
         .flag       (flags[i])
      );
   end

endmodule
